// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   ctrl_state_t : controller state encoding (RUN, MEM_WAIT, DRAIN, HALTED)
//   REG_ID_W     : register-id width used across decode/hazard logic
//   PERF_CNT_W   : width of the optional stall/flush performance counters
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned REG_ID_W   = 4;
  localparam int unsigned PERF_CNT_W = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// hazard_detect: purely combinational detection of decode-stage hazards
// against the instruction currently in EX. Kept standalone so a forwarding
// unit can reuse the same comparisons.
// Ports:
//   mem_read, reg_write, rd, flag_wr : EX-stage instruction attributes
//   src1, src2, src2_used            : decode-stage source operands
//   is_branch, is_br                 : decode-stage branch kind
//   lu  : load-use hazard
//   fh  : conditional branch waiting on flags still being produced in EX
//   brh : BR waiting on its target register still being produced in EX
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic                mem_read,
  input  logic                reg_write,
  input  logic [REG_ID_W-1:0] rd,
  input  logic                flag_wr,
  input  logic [REG_ID_W-1:0] src1,
  input  logic [REG_ID_W-1:0] src2,
  input  logic                src2_used,
  input  logic                is_branch,
  input  logic                is_br,
  output logic                lu,
  output logic                fh,
  output logic                brh
);

  logic rd_nonzero;

  // R0 is hard-wired, so writes to it never create a dependency.
  assign rd_nonzero = (rd != '0);

  assign lu  = mem_read & reg_write & rd_nonzero &
               ((rd == src1) | (src2_used & (rd == src2)));
  assign fh  = is_branch & ~is_br & flag_wr;
  assign brh = is_br & reg_write & rd_nonzero & (rd == src1);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: sequences IF/ID/EX around the decode stage.
// Generates PC / IF-ID stalls, IF-ID flush and ID-EX bubbles for load-use,
// flag-use and BR-register hazards and for branch mispredictions; freezes the
// pipe while data memory is busy; drains and halts the core on HLT.
// Parameter:
//   DRAIN_CYCLES : cycles HLT needs to reach WB before halted asserts (1..7)
// Ports:
//   clk, rst (synchronous, active-high)
//   ID_*            : decode-stage instruction info
//   ID_EX_*         : EX-stage instruction info
//   mem_busy        : data memory not ready this cycle
//   PC_stall, IF_ID_stall, IF_flush, ID_flush, pipe_freeze : combinational controls
//   halted          : registered, sticky until rst
// Optional macro PIPE_CTRL_PERF_EN adds saturating counters:
//   stall_cnt : cycles with PC_stall & !halted
//   flush_cnt : cycles with IF_flush while in RUN
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ID_W-1:0]   ID_src1,
  input  logic [REG_ID_W-1:0]   ID_src2,
  input  logic                  ID_src2_used,
  input  logic                  ID_is_branch,
  input  logic                  ID_is_BR,
  input  logic                  ID_misprediction,
  input  logic                  ID_HLT,
  input  logic                  ID_EX_MemRead,
  input  logic [REG_ID_W-1:0]   ID_EX_reg_rd,
  input  logic                  ID_EX_RegWrite,
  input  logic                  ID_EX_flag_wr,
  input  logic                  mem_busy,
  output logic                  PC_stall,
  output logic                  IF_ID_stall,
  output logic                  IF_flush,
  output logic                  ID_flush,
  output logic                  pipe_freeze,
  output logic                  halted
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);

  ctrl_state_t state, state_next;
  logic [2:0]  cnt, cnt_next;
  logic        lu, fh, brh, hz;

  hazard_detect u_hazard_detect (
    .mem_read  (ID_EX_MemRead),
    .reg_write (ID_EX_RegWrite),
    .rd        (ID_EX_reg_rd),
    .flag_wr   (ID_EX_flag_wr),
    .src1      (ID_src1),
    .src2      (ID_src2),
    .src2_used (ID_src2_used),
    .is_branch (ID_is_branch),
    .is_br     (ID_is_BR),
    .lu        (lu),
    .fh        (fh),
    .brh       (brh)
  );

  assign hz = lu | fh | brh;

  // Priority inside RUN: mem_busy > hazard > misprediction > HLT.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    PC_stall    = 1'b0;
    IF_ID_stall = 1'b0;
    IF_flush    = 1'b0;
    ID_flush    = 1'b0;
    pipe_freeze = 1'b0;
    unique case (state)
      RUN: begin
        if (mem_busy) begin
          pipe_freeze = 1'b1;
          PC_stall    = 1'b1;
          IF_ID_stall = 1'b1;
          state_next  = MEM_WAIT;
        end else if (hz) begin
          PC_stall    = 1'b1;
          IF_ID_stall = 1'b1;
          ID_flush    = 1'b1;
        end else if (ID_misprediction && ID_is_branch) begin
          IF_flush    = 1'b1;
        end else if (ID_HLT) begin
          PC_stall    = 1'b1;
          IF_flush    = 1'b1;
          cnt_next    = 3'(DRAIN_CYCLES - 1);
          state_next  = DRAIN;
        end
      end
      MEM_WAIT: begin
        if (mem_busy) begin
          pipe_freeze = 1'b1;
          PC_stall    = 1'b1;
          IF_ID_stall = 1'b1;
        end else begin
          state_next  = RUN;
        end
      end
      DRAIN: begin
        PC_stall = 1'b1;
        IF_flush = 1'b1;
        if (mem_busy) begin
          pipe_freeze = 1'b1;
        end else if (cnt == '0) begin
          state_next = HALTED;
        end else begin
          cnt_next = cnt - 3'd1;
        end
      end
      HALTED: begin
        PC_stall    = 1'b1;
        IF_ID_stall = 1'b1;
        pipe_freeze = 1'b1;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      cnt    <= '0;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      if (state_next == HALTED) halted <= 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (PC_stall && !halted && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (IF_flush && state == RUN && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (DRAIN_CYCLES = 3).
// Observed vector order: {PC_stall, IF_ID_stall, IF_flush, ID_flush, pipe_freeze, halted}.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ID_src1, ID_src2, ID_EX_reg_rd;
  logic       ID_src2_used, ID_is_branch, ID_is_BR, ID_misprediction, ID_HLT;
  logic       ID_EX_MemRead, ID_EX_RegWrite, ID_EX_flag_wr, mem_busy;
  logic       PC_stall, IF_ID_stall, IF_flush, ID_flush, pipe_freeze, halted;
`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .ID_src1          (ID_src1),
    .ID_src2          (ID_src2),
    .ID_src2_used     (ID_src2_used),
    .ID_is_branch     (ID_is_branch),
    .ID_is_BR         (ID_is_BR),
    .ID_misprediction (ID_misprediction),
    .ID_HLT           (ID_HLT),
    .ID_EX_MemRead    (ID_EX_MemRead),
    .ID_EX_reg_rd     (ID_EX_reg_rd),
    .ID_EX_RegWrite   (ID_EX_RegWrite),
    .ID_EX_flag_wr    (ID_EX_flag_wr),
    .mem_busy         (mem_busy),
    .PC_stall         (PC_stall),
    .IF_ID_stall      (IF_ID_stall),
    .IF_flush         (IF_flush),
    .ID_flush         (ID_flush),
    .pipe_freeze      (pipe_freeze),
    .halted           (halted)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
`endif
  );

  task automatic clear_inputs();
    ID_src1 = '0; ID_src2 = '0; ID_EX_reg_rd = '0;
    ID_src2_used = 1'b0; ID_is_branch = 1'b0; ID_is_BR = 1'b0;
    ID_misprediction = 1'b0; ID_HLT = 1'b0; ID_EX_MemRead = 1'b0;
    ID_EX_RegWrite = 1'b0; ID_EX_flag_wr = 1'b0; mem_busy = 1'b0;
  endtask

  // Inputs are changed just after a negedge; outputs are sampled 1 time unit later.
  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    #1;
    obs = {PC_stall, IF_ID_stall, IF_flush, ID_flush, pipe_freeze, halted};
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_lu(input logic [3:0] rd);
    ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_reg_rd = rd; ID_src1 = rd;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("reset_idle", 6'b000000);
    tick();

    // Load-use on src1
    set_lu(4'd3);
    chk("lu_src1", 6'b110100);
    tick(); clear_inputs();
    chk("lu_after", 6'b000000);
    tick();
    // Load-use on src2 only when src2 is read
    ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_reg_rd = 4'd5;
    ID_src1 = 4'd1; ID_src2 = 4'd5; ID_src2_used = 1'b1;
    chk("lu_src2", 6'b110100);
    ID_src2_used = 1'b0;
    chk("lu_src2_unused", 6'b000000);
    // Load into R0 never stalls
    clear_inputs();
    ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1;
    chk("lu_r0", 6'b000000);
    tick(); clear_inputs();

    // Flag hazard masks misprediction, which then flushes next cycle
    ID_is_branch = 1'b1; ID_EX_flag_wr = 1'b1; ID_misprediction = 1'b1;
    chk("fh_stall", 6'b110100);
    tick(); ID_EX_flag_wr = 1'b0;
    chk("fh_then_flush", 6'b001000);
    tick(); clear_inputs();
    chk("fh_clear", 6'b000000);
    // BR register hazard
    ID_is_branch = 1'b1; ID_is_BR = 1'b1; ID_EX_RegWrite = 1'b1;
    ID_EX_reg_rd = 4'd7; ID_src1 = 4'd7;
    chk("brh_stall", 6'b110100);
    // BR does not wait on flags
    ID_EX_RegWrite = 1'b0; ID_EX_flag_wr = 1'b1;
    chk("br_no_fh", 6'b000000);
    // Misprediction without a branch is ignored
    clear_inputs(); ID_misprediction = 1'b1;
    chk("mispred_nobranch", 6'b000000);
    tick(); clear_inputs();

    // mem_busy for 3 cycles; hazard inputs ignored in MEM_WAIT
    mem_busy = 1'b1;
    chk("mem_busy1", 6'b110010);
    tick(); set_lu(4'd2);
    chk("mem_busy2", 6'b110010);
    tick();
    chk("mem_busy3", 6'b110010);
    tick(); mem_busy = 1'b0;
    chk("mem_release", 6'b000000);
    tick(); clear_inputs();
    chk("mem_run_again", 6'b000000);
    tick();

    // HLT with one busy cycle mid-drain
    ID_HLT = 1'b1;
    chk("hlt_run", 6'b101000);
    tick(); ID_HLT = 1'b0;
    chk("drain_c2", 6'b101000);
    tick(); mem_busy = 1'b1;
    chk("drain_busy", 6'b101010);
    tick(); mem_busy = 1'b0;
    chk("drain_c1", 6'b101000);
    tick();
    chk("drain_c0", 6'b101000);
    tick();
    chk("halted_1", 6'b110011);
    tick(); ID_HLT = 1'b1; mem_busy = 1'b1;
    chk("halted_2", 6'b110011);
    tick(); clear_inputs();
    chk("halted_3", 6'b110011);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("rst_from_halted", 6'b000000);
    tick();

    // Reset during DRAIN discards the drain
    ID_HLT = 1'b1;
    tick(); ID_HLT = 1'b0;
    chk("drain_pre_rst", 6'b101000);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("rst_in_drain", 6'b000000);
    tick();
    chk("rst_in_drain_next", 6'b000000);
    tick();

    // Reset during MEM_WAIT: RUN is shown by the hazard producing a bubble
    mem_busy = 1'b1;
    tick();
    chk("memwait_pre_rst", 6'b110010);
    rst = 1'b1;
    tick(); rst = 1'b0; clear_inputs();
    chk("rst_in_memwait", 6'b000000);
    set_lu(4'd4);
    chk("rst_memwait_run", 6'b110100);
    tick(); clear_inputs();

`ifdef PIPE_CTRL_PERF_EN
    rst = 1'b1;
    tick(); rst = 1'b0;
    set_lu(4'd6); tick(); clear_inputs(); tick();
    set_lu(4'd9); tick(); clear_inputs(); tick();
    ID_is_branch = 1'b1; ID_misprediction = 1'b1; tick(); clear_inputs(); tick();
    #1;
    n_checks++;
    assert (stall_cnt === 16'd2) else begin
      n_fail++;
      $error("FAIL stall_cnt: observed %0d expected 2", stall_cnt);
    end
    n_checks++;
    assert (flush_cnt === 16'd1) else begin
      n_fail++;
      $error("FAIL flush_cnt: observed %0d expected 1", flush_cnt);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
